trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC driven on redirect_pc_o while in reset.
REQ-002 SHALL have parameter TRAP_CNT_W, default 16, width of the trap counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port instr_valid_i  input  1  an instruction is at the commit point this cycle.
REQ-006 SHALL have port pc_i  input  32  PC of that instruction.
REQ-007 SHALL have port instr_i  input  32  encoding of that instruction.
REQ-008 SHALL have port fault_addr_i  input  32  faulting load/store/fetch address.
REQ-009 SHALL have ports instr_misaligned_i, illegal_instr_i, ebreak_i, load_misaligned_i, store_misaligned_i, ecall_i, mret_i  input  1 each  decoded events.
REQ-010 SHALL have port mtime_exc_i  input  1  timer interrupt pending and enabled, from the CSR unit.
REQ-011 SHALL have ports mtvec_i, mepc_i  input  32 each  current CSR values.
REQ-012 SHALL have ports excRequest_o  output  1, excCause_o  output  32, trapInfo_o  output  32, excPc_o  output  32  to the CSR unit.
REQ-013 SHALL have ports stall_o  output  1, redirect_o  output  1, redirect_pc_o  output  32  to the fetch/commit stage.
REQ-014 SHALL have ports mret_o  output  1 and trap_cnt_o  output  TRAP_CNT_W.

Function
REQ-015 SHALL implement the FSM states IDLE, SAVE, VECTOR and RETURN.
REQ-016 SHALL sample events only in IDLE, and only when instr_valid_i=1.
REQ-017 SHALL resolve event priority, highest first, as: mtime_exc_i (cause 32'h8000_0007), instr_misaligned (0), illegal (2), ebreak (3), load_misaligned (4), store_misaligned (6), ecall (11).
REQ-018 SHALL, when any event is taken in cycle N, latch cause, PC and info and enter SAVE at N+1; stall_o SHALL be combinationally 1 in cycle N.
REQ-019 SHALL, in SAVE, assert excRequest_o=1 for exactly one cycle, with excCause_o, excPc_o and trapInfo_o driven from the latched values; the next state is VECTOR.
REQ-020 SHALL, in VECTOR, assert redirect_o=1 for one cycle with redirect_pc_o = {mtvec_i[31:2],2'b00}; the next state is IDLE.
REQ-021 SHALL drive trapInfo_o as follows: misaligned and load/store events give fault_addr_i; illegal gives instr_i; ebreak gives pc_i; interrupt and ecall give 0.
REQ-022 SHALL, on mret_i with no trap event in cycle N, enter RETURN at N+1 and assert redirect_o=1, mret_o=1 and redirect_pc_o=mepc_i for one cycle, then return to IDLE.
REQ-023 SHALL give a trap event priority over mret_i when both occur in the same cycle; in that case mret_o SHALL stay 0.
REQ-024 SHALL hold stall_o=1 in every cycle the FSM is outside IDLE.
REQ-025 SHALL ignore all inputs except rst_n outside IDLE, so that no event is queued.
REQ-026 SHALL increment trap_cnt_o by 1 on each SAVE entry, wrapping modulo 2^TRAP_CNT_W; mret SHALL NOT count.
REQ-027 SHALL drive excRequest_o, redirect_o and mret_o to 0 whenever the FSM is not in the state that asserts them.

Reset
REQ-028 SHALL, on rst_n=0, immediately and asynchronously go to IDLE, including mid-SAVE, mid-VECTOR or mid-RETURN.
REQ-029 SHALL, during reset, drive all outputs to 0 except redirect_pc_o=RESET_VECTOR; trap_cnt_o SHALL be 0.
REQ-030 SHALL, after rst_n deasserts, first sample events on the first rising edge.

Configuration
REQ-031 SHALL support the macro TRAP_CTRL_VECTORED_INT_EN.
REQ-032 SHALL, when TRAP_CTRL_VECTORED_INT_EN is defined, set the interrupt redirect_pc_o to {mtvec_i[31:2],2'b00} + 4*excCause_o[30:0].
REQ-033 SHALL, when TRAP_CTRL_VECTORED_INT_EN is undefined, send all traps to {mtvec_i[31:2],2'b00}; exceptions SHALL always use the base address in either case.

Structure
REQ-034 SHALL place the cause constants (M_TIMER_INT and exception codes) and the FSM state enum trap_state_t in riscV_unrn_pkg.
REQ-035 SHALL place the priority resolution in the combinational sub-module trap_prio_enc (event vector in, valid/cause/info out).

Verification
REQ-036 SHALL cover: illegal_instr_i=1, pc_i=32'h100, instr_i=32'hFFFF_FFFF, mtvec_i=32'h200 -> SAVE: excRequest_o=1, cause 2, trapInfo 32'hFFFF_FFFF, excPc 32'h100; VECTOR: redirect_pc_o=32'h200; trap_cnt_o=1.
REQ-037 SHALL cover: mtime_exc_i=1 together with ecall_i=1, pc_i=32'h40 -> excCause_o=32'h8000_0007, trapInfo_o=0, excPc_o=32'h40; with the macro defined, redirect_pc_o=mtvec_base+28.
REQ-038 SHALL cover: mret_i=1, mepc_i=32'h84 -> one cycle later redirect_o=1, mret_o=1, redirect_pc_o=32'h84; excRequest_o=0; trap_cnt_o unchanged.
REQ-039 SHALL cover: load_misaligned_i held high through SAVE/VECTOR with fault_addr_i=32'h1003 -> exactly one trap, cause 4, trapInfo 32'h1003.
REQ-040 SHALL cover: rst_n pulsed low during SAVE -> outputs 0 and state IDLE without a clock edge; the trap is not completed.
REQ-041 SHALL cover: 2^TRAP_CNT_W consecutive traps -> trap_cnt_o wraps to 0.

Source files
------------

// File: rtl/riscV_unrn_pkg.sv
// Shared trap-controller types: cause codes, FSM state enum and the decoded event vector.
package riscV_unrn_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] M_TIMER_INT          = 32'h8000_0007;
   localparam logic [XLEN-1:0] EXC_INSTR_MISALIGNED = 32'd0;
   localparam logic [XLEN-1:0] EXC_ILLEGAL_INSTR    = 32'd2;
   localparam logic [XLEN-1:0] EXC_BREAKPOINT       = 32'd3;
   localparam logic [XLEN-1:0] EXC_LOAD_MISALIGNED  = 32'd4;
   localparam logic [XLEN-1:0] EXC_STORE_MISALIGNED = 32'd6;
   localparam logic [XLEN-1:0] EXC_ECALL_M          = 32'd11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAVE   = 2'd1,
      VECTOR = 2'd2,
      RETURN = 2'd3
   } trap_state_t;

   typedef struct packed {
      logic mtime;
      logic instr_mis;
      logic illegal;
      logic ebreak;
      logic load_mis;
      logic store_mis;
      logic ecall;
   } trap_evt_t;

   // Trap vector base: mtvec with the mode bits cleared.
   function automatic logic [XLEN-1:0] vec_base(input logic [XLEN-1:0] mtvec);
      return {mtvec[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational trap priority encoder: picks the highest-priority event and its cause/info word.
module trap_prio_enc
   import riscV_unrn_pkg::*;
(
   input  trap_evt_t       evt_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] fault_addr_i,
   output logic            valid_c,
   output logic [XLEN-1:0] cause_c,
   output logic [XLEN-1:0] info_c
);

   always_comb begin
      valid_c = 1'b1;
      cause_c = '0;
      info_c  = '0;
      if (evt_i.mtime) begin
         cause_c = M_TIMER_INT;
      end else if (evt_i.instr_mis) begin
         cause_c = EXC_INSTR_MISALIGNED;
         info_c  = fault_addr_i;
      end else if (evt_i.illegal) begin
         cause_c = EXC_ILLEGAL_INSTR;
         info_c  = instr_i;
      end else if (evt_i.ebreak) begin
         cause_c = EXC_BREAKPOINT;
         info_c  = pc_i;
      end else if (evt_i.load_mis) begin
         cause_c = EXC_LOAD_MISALIGNED;
         info_c  = fault_addr_i;
      end else if (evt_i.store_mis) begin
         cause_c = EXC_STORE_MISALIGNED;
         info_c  = fault_addr_i;
      end else if (evt_i.ecall) begin
         cause_c = EXC_ECALL_M;
      end else begin
         valid_c = 1'b0;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: IDLE -> SAVE -> VECTOR for traps, IDLE -> RETURN for mret.
// Build option TRAP_CTRL_VECTORED_INT_EN: interrupts vector to base + 4*cause.
module trap_ctrl
   import riscV_unrn_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned TRAP_CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid_i,
   input  logic [31:0]           pc_i,
   input  logic [31:0]           instr_i,
   input  logic [31:0]           fault_addr_i,
   input  logic                  instr_misaligned_i,
   input  logic                  illegal_instr_i,
   input  logic                  ebreak_i,
   input  logic                  load_misaligned_i,
   input  logic                  store_misaligned_i,
   input  logic                  ecall_i,
   input  logic                  mret_i,
   input  logic                  mtime_exc_i,
   input  logic [31:0]           mtvec_i,
   input  logic [31:0]           mepc_i,
   output logic                  excRequest_o,
   output logic [31:0]           excCause_o,
   output logic [31:0]           trapInfo_o,
   output logic [31:0]           excPc_o,
   output logic                  stall_o,
   output logic                  redirect_o,
   output logic [31:0]           redirect_pc_o,
   output logic                  mret_o,
   output logic [TRAP_CNT_W-1:0] trap_cnt_o
);

   trap_state_t           state_q, state_d;
   logic [31:0]           cause_q, cause_d;
   logic [31:0]           epc_q, epc_d;
   logic [31:0]           info_q, info_d;
   logic [TRAP_CNT_W-1:0] cnt_q, cnt_d;

   trap_evt_t   evt;
   logic        enc_valid_c;
   logic [31:0] enc_cause_c;
   logic [31:0] enc_info_c;
   logic [31:0] vec_off;

   assign evt = '{mtime:     mtime_exc_i,
                  instr_mis: instr_misaligned_i,
                  illegal:   illegal_instr_i,
                  ebreak:    ebreak_i,
                  load_mis:  load_misaligned_i,
                  store_mis: store_misaligned_i,
                  ecall:     ecall_i};

   trap_prio_enc u_prio (
      .evt_i        (evt),
      .pc_i         (pc_i),
      .instr_i      (instr_i),
      .fault_addr_i (fault_addr_i),
      .valid_c      (enc_valid_c),
      .cause_c      (enc_cause_c),
      .info_c       (enc_info_c)
   );

`ifdef TRAP_CTRL_VECTORED_INT_EN
   // Interrupt causes have bit 31 set; exceptions keep the base address.
   assign vec_off = cause_q[31] ? {cause_q[29:0], 2'b00} : 32'd0;
`else
   assign vec_off = 32'd0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cause_q <= '0;
         epc_q   <= '0;
         info_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
         info_q  <= info_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode the state register; stall in IDLE must react to this cycle's events.
   always_comb begin
      state_d       = state_q;
      cause_d       = cause_q;
      epc_d         = epc_q;
      info_d        = info_q;
      cnt_d         = cnt_q;
      stall_o       = 1'b0;
      excRequest_o  = 1'b0;
      excCause_o    = '0;
      trapInfo_o    = '0;
      excPc_o       = '0;
      redirect_o    = 1'b0;
      redirect_pc_o = RESET_VECTOR;
      mret_o        = 1'b0;

      case (state_q)
         IDLE: begin
            if (rst_n && instr_valid_i) begin
               if (enc_valid_c) begin
                  state_d = SAVE;
                  cause_d = enc_cause_c;
                  epc_d   = pc_i;
                  info_d  = enc_info_c;
                  cnt_d   = cnt_q + TRAP_CNT_W'(1);
                  stall_o = 1'b1;
               end else if (mret_i) begin
                  state_d = RETURN;
                  stall_o = 1'b1;
               end
            end
         end
         SAVE: begin
            stall_o      = 1'b1;
            excRequest_o = 1'b1;
            excCause_o   = cause_q;
            trapInfo_o   = info_q;
            excPc_o      = epc_q;
            state_d      = VECTOR;
         end
         VECTOR: begin
            stall_o       = 1'b1;
            redirect_o    = 1'b1;
            redirect_pc_o = vec_base(mtvec_i) + vec_off;
            state_d       = IDLE;
         end
         RETURN: begin
            stall_o       = 1'b1;
            redirect_o    = 1'b1;
            mret_o        = 1'b1;
            redirect_pc_o = mepc_i;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign trap_cnt_o = cnt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a transaction-level model queues expected CSR requests and redirects.
module tb_trap_ctrl;

   localparam int unsigned CW       = 4;
   localparam logic [31:0] RST_VEC  = 32'h8000_0000;
   localparam logic [31:0] CAUSE_TBL [7] = '{32'h8000_0007, 32'd0, 32'd2, 32'd3, 32'd4, 32'd6, 32'd11};
   // info source per event: 0 zero, 1 fault address, 2 instruction, 3 pc
   localparam int          INFO_TBL  [7] = '{0, 1, 2, 3, 1, 1, 0};

   typedef struct {
      logic [31:0]   cause;
      logic [31:0]   info;
      logic [31:0]   pc;
      logic [CW-1:0] cnt;
   } exc_t;

   typedef struct {
      logic [31:0]   pc;
      logic          mret;
      logic [CW-1:0] cnt;
   } rd_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          instr_valid_i;
   logic [31:0]   pc_i, instr_i, fault_addr_i, mtvec_i, mepc_i;
   logic          instr_misaligned_i, illegal_instr_i, ebreak_i, load_misaligned_i;
   logic          store_misaligned_i, ecall_i, mret_i, mtime_exc_i;
   logic          excRequest_o, stall_o, redirect_o, mret_o;
   logic [31:0]   excCause_o, trapInfo_o, excPc_o, redirect_pc_o;
   logic [CW-1:0] trap_cnt_o;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   exc_t        exc_q[$];
   rd_t         rd_q[$];
   int          busy   = 0;
   logic [CW-1:0] cnt_m = '0;
   bit          mon_en = 1'b0;
   bit          exp_stall = 1'b0;
   logic [31:0] cur_mtvec, cur_mepc;

   trap_ctrl #(.RESET_VECTOR(RST_VEC), .TRAP_CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid_i), .pc_i(pc_i),
      .instr_i(instr_i), .fault_addr_i(fault_addr_i),
      .instr_misaligned_i(instr_misaligned_i), .illegal_instr_i(illegal_instr_i),
      .ebreak_i(ebreak_i), .load_misaligned_i(load_misaligned_i),
      .store_misaligned_i(store_misaligned_i), .ecall_i(ecall_i), .mret_i(mret_i),
      .mtime_exc_i(mtime_exc_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
      .excRequest_o(excRequest_o), .excCause_o(excCause_o), .trapInfo_o(trapInfo_o),
      .excPc_o(excPc_o), .stall_o(stall_o), .redirect_o(redirect_o),
      .redirect_pc_o(redirect_pc_o), .mret_o(mret_o), .trap_cnt_o(trap_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic set_idle_inputs();
      instr_valid_i = 1'b0; mret_i = 1'b0;
      {ecall_i, store_misaligned_i, load_misaligned_i, ebreak_i,
       illegal_instr_i, instr_misaligned_i, mtime_exc_i} = 7'd0;
   endtask

   // Drive one commit cycle and advance the reference model.
   task automatic step(input bit v, input bit [6:0] ev, input bit mr,
                       input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] fa,
                       input logic [31:0] mtvec, input logic [31:0] mepc);
      int          idx;
      logic [31:0] info, tgt;
      @(posedge clk); #1;
      instr_valid_i = v; pc_i = pc; instr_i = ins; fault_addr_i = fa; mret_i = mr;
      {ecall_i, store_misaligned_i, load_misaligned_i, ebreak_i,
       illegal_instr_i, instr_misaligned_i, mtime_exc_i} = ev;
      if (busy == 0) begin
         mtvec_i = mtvec; mepc_i = mepc;
      end
      if (busy > 0) begin
         busy--;
         exp_stall = 1'b1;
      end else if (v && ev != 7'd0) begin
         idx = 0;
         while (!ev[idx]) idx++;
         case (INFO_TBL[idx])
            1:       info = fa;
            2:       info = ins;
            3:       info = pc;
            default: info = 32'd0;
         endcase
         cnt_m = cnt_m + 1'b1;
         tgt = mtvec & ~32'd3;
`ifdef TRAP_CTRL_VECTORED_INT_EN
         if (CAUSE_TBL[idx][31]) tgt = tgt + 4 * (CAUSE_TBL[idx] & 32'h7fff_ffff);
`endif
         exc_q.push_back('{cause: CAUSE_TBL[idx], info: info, pc: pc, cnt: cnt_m});
         rd_q.push_back('{pc: tgt, mret: 1'b0, cnt: cnt_m});
         busy = 2;
         exp_stall = 1'b1;
      end else if (v && mr) begin
         rd_q.push_back('{pc: mepc, mret: 1'b1, cnt: cnt_m});
         busy = 1;
         exp_stall = 1'b1;
      end else begin
         exp_stall = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 7'd0, 0, 32'd0, 32'd0, 32'd0, cur_mtvec, cur_mepc);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".excRequest"}, 32'(excRequest_o), 32'd0);
      chk({tag, ".stall"},      32'(stall_o), 32'd0);
      chk({tag, ".redirect"},   32'(redirect_o), 32'd0);
      chk({tag, ".mret"},       32'(mret_o), 32'd0);
      chk({tag, ".excCause"},   excCause_o, 32'd0);
      chk({tag, ".trapInfo"},   trapInfo_o, 32'd0);
      chk({tag, ".excPc"},      excPc_o, 32'd0);
      chk({tag, ".trap_cnt"},   32'(trap_cnt_o), 32'd0);
      chk({tag, ".redirect_pc"}, redirect_pc_o, RST_VEC);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a request or redirect.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         exc_t e;
         rd_t  r;
         chk("stall", 32'(stall_o), 32'(exp_stall));
         if (excRequest_o) begin
            if (exc_q.size() == 0) begin
               chk("unexpected_excRequest", 32'd1, 32'd0);
            end else begin
               e = exc_q.pop_front();
               chk("excCause", excCause_o, e.cause);
               chk("trapInfo", trapInfo_o, e.info);
               chk("excPc", excPc_o, e.pc);
               chk("trap_cnt_save", 32'(trap_cnt_o), 32'(e.cnt));
               chk("save_no_redirect", 32'(redirect_o), 32'd0);
            end
         end
         if (redirect_o) begin
            if (rd_q.size() == 0) begin
               chk("unexpected_redirect", 32'd1, 32'd0);
            end else begin
               r = rd_q.pop_front();
               chk("redirect_pc", redirect_pc_o, r.pc);
               chk("mret_o", 32'(mret_o), 32'(r.mret));
               chk("trap_cnt_redirect", 32'(trap_cnt_o), 32'(r.cnt));
            end
         end else if (mret_o) begin
            chk("mret_without_redirect", 32'd1, 32'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] m_tv, m_ep;
      rst_n = 1'b0;
      set_idle_inputs();
      pc_i = '0; instr_i = '0; fault_addr_i = '0;
      cur_mtvec = 32'h200; cur_mepc = 32'h84;
      mtvec_i = cur_mtvec; mepc_i = cur_mepc;
      #13;
      check_reset_outputs("reset");
      #9;
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Illegal instruction at 0x100
      step(1, 7'b0000100, 0, 32'h100, 32'hFFFF_FFFF, 32'h55, cur_mtvec, cur_mepc);
      idle(3);
      // Timer interrupt beats ecall; mode bits of mtvec ignored
      cur_mtvec = 32'h301;
      step(1, 7'b1000001, 0, 32'h40, 32'h1234, 32'h99, cur_mtvec, cur_mepc);
      idle(3);
      // mret with no trap
      step(1, 7'd0, 1, 32'h60, 32'h0, 32'h0, cur_mtvec, 32'h84);
      idle(2);
      // Trap beats mret in the same cycle
      step(1, 7'b0001000, 1, 32'h70, 32'h0, 32'h0, cur_mtvec, cur_mepc);
      idle(3);
      // Load misaligned held through SAVE/VECTOR gives one trap
      for (int i = 0; i < 3; i++) step(1, 7'b0010000, 0, 32'h80, 32'h0, 32'h1003, cur_mtvec, cur_mepc);
      idle(3);

      // Reset pulse while in SAVE
      mon_en = 1'b0;
      step(1, 7'b0000100, 0, 32'h100, 32'hDEAD_BEEF, 32'h0, cur_mtvec, cur_mepc);
      @(negedge clk);
      @(negedge clk);
      chk("save_before_reset", 32'(excRequest_o), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_save_reset");
      set_idle_inputs();
      exc_q.delete(); rd_q.delete();
      busy = 0; cnt_m = '0; exp_stall = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_no_vector", 32'(redirect_o), 32'd0);
      chk("post_reset_no_request", 32'(excRequest_o), 32'd0);
      mon_en = 1'b1;

      // Counter wrap: 2^CW back-to-back ecalls
      for (int i = 0; i < 3 * (1 << CW); i++) step(1, 7'b1000000, 0, 32'h400, 32'h0, 32'h0, cur_mtvec, cur_mepc);
      idle(3);
      chk("trap_cnt_wrap", 32'(trap_cnt_o), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bit [6:0] ev;
         for (int b = 0; b < 7; b++) ev[b] = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 9) == 0) cur_mtvec = $urandom;
         if ($urandom_range(0, 9) == 0) cur_mepc = $urandom;
         m_tv = cur_mtvec; m_ep = cur_mepc;
         step($urandom_range(0, 3) != 0, ev, $urandom_range(0, 5) == 0,
              $urandom, $urandom, $urandom, m_tv, m_ep);
      end
      idle(4);
      chk("exc_queue_drained", 32'(exc_q.size()), 32'd0);
      chk("redirect_queue_drained", 32'(rd_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
